wb_merge_stage: RTL and testbench
=================================

// Module: wb_merge_stage
// PURPOSE
//  Writeback merge stage feeding the register file's single write port (writeBackEn/Dest_wb/Result_WB).
//  Merges two producers: the in-order ALU/WB pipeline channel and the late load-return channel of the multi-cycle SRAM controller.
//  Queues requests in a small FIFO and retires one write per cycle.
//  Reports a RAW hazard to the hazard unit for any still-pending destination.
// PARAMETERS
//  DEPTH   4   FIFO entries; minimum 2
//  DATA_W  32  result width
//  REG_AW  4   register index width
// PORTS
//  clk          in   1       system clock; all state updates on posedge
//  rst          in   1       asynchronous, active-high reset
//  alu_valid    in   1       ALU-channel request present
//  alu_ready    out  1       ALU-channel request may be accepted this cycle
//  alu_wb_en    in   1       request really writes a register
//  alu_dest     in   REG_AW  destination register
//  alu_result   in   DATA_W  ALU result
//  ld_valid     in   1       load return; no backpressure, always accepted
//  ld_dest      in   REG_AW  load destination register
//  ld_data      in   DATA_W  load data
//  src1, src2   in   REG_AW  decode-stage source registers
//  two_src      in   1       src2 is used
//  hazard       out  1       src1 (or src2 when two_src) matches a pending destination
//  writeBackEn  out  1       register file write enable
//  Dest_wb      out  REG_AW  register file write address
//  Result_WB    out  DATA_W  register file write data
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): FIFO emptied, pointers and count = 0.
//    Outputs: writeBackEn=0, Dest_wb=0, Result_WB=0, hazard=0; alu_ready=1 once rst deasserts.
//  - Filtering: a request with wb_en=0 (ALU channel only) or dest==0 is accepted and discarded.
//    It occupies no slot; this matches the register file's R0 write restriction.
//  - Push order: when both channels push in one cycle, the load entry is enqueued ahead of the ALU entry.
//  - Pop: whenever the FIFO is non-empty, the head is popped at every posedge.
//    The register file always accepts a write.
//  - Write port is combinational from the FIFO head.
//    writeBackEn = !empty; Dest_wb/Result_WB = head fields, or 0 when empty.
//    The register file samples the port on negedge of the same cycle.
//  - alu_ready = (DEPTH - count) >= 2.
//    This reserves a slot for an unthrottled load return, so the FIFO never overflows.
//    A load arriving while alu_ready=0 still fits.
//  - Latency, without bypass: accept at edge N -> on write port during cycle N..N+1; written at that negedge.
//  - Count update per cycle: count + pushes - pop, where pushes ∈ {0,1,2}; pointers wrap modulo DEPTH.
//  - hazard: combinational OR over valid FIFO entries of (dest==src1) | (two_src & dest==src2).
//    Cleared when the last matching entry pops.
//  - No ordering check between the channels: the issue logic never has two in-flight writes to the same register.
// CONFIGURATION
//  Macro WB_BYPASS_EN:
//  - Defined: if the FIFO is empty and exactly one valid, unfiltered request arrives, it drives the write port combinationally in the same cycle and is not enqueued.
//    Latency is 0. hazard also compares the incoming ALU/load destinations.
//  - Not defined: every request goes through the FIFO; latency is 1 cycle; no combinational path from input to the write port.
// STRUCTURE
//  - Shared header wb_defs.vh: REG_AW/DATA_W defaults, R0 index constant, FIFO entry field layout {dest, data}.
//  - Sub-module wb_fifo: parameterised DEPTH FIFO with dual push (push0 before push1), single pop, count, and per-entry valid/dest taps for the hazard compare.
//  - Top level holds filtering, the push-order mux, the bypass, the hazard compare and the output drive.
// TESTING
//  1. Reset mid-stream: fill 3 entries, pulse rst -> writeBackEn=0, Dest_wb=0, hazard=0, alu_ready=1 immediately.
//  2. Single ALU write: alu_dest=5, alu_result=0xDEADBEEF.
//     Without bypass: next cycle writeBackEn=1, Dest_wb=5, Result_WB=0xDEADBEEF for exactly 1 cycle.
//     With bypass: the same values in the same cycle.
//  3. Simultaneous push: ld (R3, 0x11) and alu (R4, 0x22) in one cycle -> write port shows R3 then R4 on consecutive cycles.
//  4. Backpressure: hold loads every cycle with ALU requests.
//     alu_ready drops at count=DEPTH-1; no write is lost or duplicated; the scoreboard matches the write order.
//  5. Filtering: alu_wb_en=0 dest=7, and ld_dest=0 -> no register file write, count unchanged.
//  6. Hazard: R9 pending, src1=9 -> hazard=1. src2=9 with two_src=0 -> hazard=0. hazard=0 the cycle after R9 pops.

Source files
------------

// File: rtl/wb_merge_stage_pkg.sv
// Shared definitions for the writeback merge stage: default widths, the R0 index
// and the request-keep rule used on both producer channels.
package wb_merge_stage_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;
  localparam int R0_IDX     = 0;

  // A request only occupies a slot when it really writes a register other than R0.
  function automatic logic req_kept(input logic valid, input logic wb_en, input logic dest_is_r0);
    return valid & wb_en & ~dest_is_r0;
  endfunction

endpackage

// File: rtl/wb_merge_stage_if.sv
// Producer channels, decode source taps and register-file write port of the merge stage.
interface wb_merge_stage_if
  import wb_merge_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
);

  logic              alu_valid;
  logic              alu_ready;
  logic              alu_wb_en;
  logic [REG_AW-1:0] alu_dest;
  logic [DATA_W-1:0] alu_result;
  logic              ld_valid;
  logic [REG_AW-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              two_src;
  logic              hazard;
  logic              writeBackEn;
  logic [REG_AW-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB;

  modport master (
    output alu_valid, alu_wb_en, alu_dest, alu_result,
    output ld_valid, ld_dest, ld_data, src1, src2, two_src,
    input  alu_ready, hazard, writeBackEn, Dest_wb, Result_WB
  );

  modport slave (
    input  alu_valid, alu_wb_en, alu_dest, alu_result,
    input  ld_valid, ld_dest, ld_data, src1, src2, two_src,
    output alu_ready, hazard, writeBackEn, Dest_wb, Result_WB
  );

endinterface

// File: rtl/wb_merge_stage_fifo.sv
// Writeback FIFO: dual push (push0 lands ahead of push1), one pop per cycle while
// non-empty, with per-entry valid/dest taps for the hazard compare.
module wb_merge_stage_fifo
  import wb_merge_stage_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  REG_AW = REG_AW_DEF,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int ENT_W  = REG_AW + DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push0,
  input  logic [ENT_W-1:0]             push0_entry,
  input  logic                         push1,
  input  logic [ENT_W-1:0]             push1_entry,
  output logic [CNT_W-1:0]             count,
  output logic                         empty,
  output logic [ENT_W-1:0]             head,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] entry_dest
);

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_nx_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_nx1_s;
  logic [PTR_W-1:0] wr_ptr_nx_s;
  logic [PTR_W-1:0] rd_ptr_nx_s;
  logic [PTR_W-1:0] slot1_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nx_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Next pointers, occupancy and valid bits from this cycle's pushes and pop.
  always_comb begin
    wr_ptr_nx1_s = ptr_inc(wr_ptr_r);
    slot1_s      = push0 ? wr_ptr_nx1_s : wr_ptr_r;
    pop_s        = (count_r != {CNT_W{1'b0}});
    rd_ptr_nx_s  = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    count_nx_s   = count_r + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_s);
    case ({push0, push1})
      2'b11:        wr_ptr_nx_s = ptr_inc(wr_ptr_nx1_s);
      2'b10, 2'b01: wr_ptr_nx_s = wr_ptr_nx1_s;
      default:      wr_ptr_nx_s = wr_ptr_r;
    endcase
    valid_nx_s = valid_r;
    for (int i = 0; i < DEPTH; i++) begin
      valid_nx_s[i] = (valid_r[i] & ~(pop_s & (rd_ptr_r == PTR_W'(i))))
                    | (push0 & (wr_ptr_r == PTR_W'(i)))
                    | (push1 & (slot1_s == PTR_W'(i)));
    end
  end

  // FIFO state and entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {ENT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nx_s;
      rd_ptr_r <= rd_ptr_nx_s;
      count_r  <= count_nx_s;
      valid_r  <= valid_nx_s;
      for (int i = 0; i < DEPTH; i++) begin
        if (push0 && (wr_ptr_r == PTR_W'(i))) mem_r[i] <= push0_entry;
        else if (push1 && (slot1_s == PTR_W'(i))) mem_r[i] <= push1_entry;
      end
    end
  end

  // Head and hazard taps.
  always_comb begin
    count       = count_r;
    empty       = (count_r == {CNT_W{1'b0}});
    head        = mem_r[rd_ptr_r];
    entry_valid = valid_r;
    for (int i = 0; i < DEPTH; i++) entry_dest[i] = mem_r[i][ENT_W-1 -: REG_AW];
  end

endmodule

// File: rtl/wb_merge_stage.sv
// Writeback merge stage: filters and orders ALU and load-return writes into the FIFO and
// drives the register-file write port. Optional same-cycle bypass under macro WB_BYPASS_EN.
module wb_merge_stage
  import wb_merge_stage_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  REG_AW = REG_AW_DEF,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int ENT_W  = REG_AW + DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  wb_merge_stage_if.slave bus
);

  // One slot is always held back so an unthrottled load return still fits.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic                         ld_keep_s;
  logic                         alu_keep_s;
  logic                         alu_ready_s;
  logic                         byp_s;
  logic                         push0_s;
  logic                         push1_s;
  logic [ENT_W-1:0]             ld_entry_s;
  logic [ENT_W-1:0]             alu_entry_s;
  logic [ENT_W-1:0]             in_entry_s;
  logic [CNT_W-1:0]             count_s;
  logic                         empty_s;
  logic [ENT_W-1:0]             head_s;
  logic [DEPTH-1:0]             entry_valid_s;
  logic [DEPTH-1:0][REG_AW-1:0] entry_dest_s;
  logic                         hazard_s;

  function automatic logic dest_hit(input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s1,
                                    input logic [REG_AW-1:0] s2, input logic ts);
    return (d == s1) | (ts & (d == s2));
  endfunction

  // Request filtering, load-first push ordering and bypass selection.
  always_comb begin
    alu_ready_s = (count_s <= READY_MAX);
    ld_keep_s   = req_kept(bus.ld_valid, 1'b1, bus.ld_dest == REG_AW'(R0_IDX));
    alu_keep_s  = req_kept(bus.alu_valid & alu_ready_s, bus.alu_wb_en,
                           bus.alu_dest == REG_AW'(R0_IDX));
    ld_entry_s  = {bus.ld_dest, bus.ld_data};
    alu_entry_s = {bus.alu_dest, bus.alu_result};
    in_entry_s  = ld_keep_s ? ld_entry_s : alu_entry_s;
`ifdef WB_BYPASS_EN
    byp_s       = empty_s & (ld_keep_s ^ alu_keep_s);
`else
    byp_s       = 1'b0;
`endif
    push0_s     = (ld_keep_s | alu_keep_s) & ~byp_s;
    push1_s     = ld_keep_s & alu_keep_s;
  end

  wb_merge_stage_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (push0_s),
    .push0_entry (in_entry_s),
    .push1       (push1_s),
    .push1_entry (alu_entry_s),
    .count       (count_s),
    .empty       (empty_s),
    .head        (head_s),
    .entry_valid (entry_valid_s),
    .entry_dest  (entry_dest_s)
  );

  // RAW hazard over every pending destination.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_s = hazard_s | (entry_valid_s[i] & dest_hit(entry_dest_s[i], bus.src1, bus.src2, bus.two_src));
    end
`ifdef WB_BYPASS_EN
    hazard_s = hazard_s
             | (ld_keep_s & dest_hit(bus.ld_dest, bus.src1, bus.src2, bus.two_src))
             | (alu_keep_s & dest_hit(bus.alu_dest, bus.src1, bus.src2, bus.two_src));
`endif
  end

  // Register-file write port: FIFO head first, otherwise a bypassed request, otherwise idle.
  always_comb begin
    bus.alu_ready = alu_ready_s;
    bus.hazard    = hazard_s;
    if (!empty_s) begin
      bus.writeBackEn              = 1'b1;
      {bus.Dest_wb, bus.Result_WB} = head_s;
    end else if (byp_s) begin
      bus.writeBackEn              = 1'b1;
      {bus.Dest_wb, bus.Result_WB} = in_entry_s;
    end else begin
      bus.writeBackEn              = 1'b0;
      {bus.Dest_wb, bus.Result_WB} = {ENT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_wb_merge_stage.sv
// Scoreboard bench for wb_merge_stage (default build): stimulus pushes expected writes,
// a negedge monitor pops and compares the write port and hazard.
module tb_wb_merge_stage;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  wr_t  staged_q[$];

  wb_merge_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_merge_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called #1 after a posedge: exp_q then holds exactly what the FIFO holds.
  task automatic drive(input bit av, input bit ae, input logic [3:0] ad, input logic [31:0] ar,
                       input bit lv, input logic [3:0] lt, input logic [31:0] lx,
                       input logic [3:0] s1, input logic [3:0] s2, input bit ts);
    bit ready_m;
    ready_m = (DEPTH - exp_q.size()) >= 2;
    check("alu_ready", 32'(bus.alu_ready), 32'(ready_m));
    bus.alu_valid  = av;
    bus.alu_wb_en  = ae;
    bus.alu_dest   = ad;
    bus.alu_result = ar;
    bus.ld_valid   = lv;
    bus.ld_dest    = lt;
    bus.ld_data    = lx;
    bus.src1       = s1;
    bus.src2       = s2;
    bus.two_src    = ts;
    if (lv && lt != 4'd0) staged_q.push_back(wr_t'({lt, lx}));
    if (av && ready_m && ae && ad != 4'd0) staged_q.push_back(wr_t'({ad, ar}));
    @(posedge clk);
    #1;
    while (staged_q.size() != 0) exp_q.push_back(staged_q.pop_front());
  endtask

  task automatic idle(input logic [3:0] s1, input logic [3:0] s2, input bit ts);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, s1, s2, ts);
  endtask

  task automatic pulse_reset();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.src1      = 4'd3;
    bus.two_src   = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    staged_q.delete();
    #1;
    check("rst_wb_en", 32'(bus.writeBackEn), 32'd0);
    check("rst_dest", 32'(bus.Dest_wb), 32'd0);
    check("rst_hazard", 32'(bus.hazard), 32'd0);
    check("rst_ready", 32'(bus.alu_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: the write port must show the oldest pending write; hazard follows pending dests.
  always @(negedge clk) begin
    bit  hz;
    wr_t e;
    hz = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i].dest == bus.src1 || (bus.two_src && exp_q[i].dest == bus.src2)) hz = 1'b1;
    end
    check("hazard", 32'(bus.hazard), 32'(hz));
    check("wb_en", 32'(bus.writeBackEn), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wb_dest", 32'(bus.Dest_wb), 32'(e.dest));
      check("wb_data", bus.Result_WB, e.data);
    end else begin
      check("idle_dest", 32'(bus.Dest_wb), 32'd0);
      check("idle_data", bus.Result_WB, 32'd0);
    end
  end

  initial begin
    bus.alu_valid  = 1'b0;
    bus.alu_wb_en  = 1'b0;
    bus.alu_dest   = 4'd0;
    bus.alu_result = 32'd0;
    bus.ld_valid   = 1'b0;
    bus.ld_dest    = 4'd0;
    bus.ld_data    = 32'd0;
    bus.src1       = 4'd0;
    bus.src2       = 4'd0;
    bus.two_src    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single ALU write.
    drive(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0);
    idle(4'd5, 4'd0, 1'b0);
    idle(4'd5, 4'd0, 1'b0);

    // Simultaneous push: load R3 then ALU R4.
    drive(1'b1, 1'b1, 4'd4, 32'h22, 1'b1, 4'd3, 32'h11, 4'd0, 4'd0, 1'b0);
    idle(4'd3, 4'd4, 1'b1);
    idle(4'd3, 4'd4, 1'b1);

    // Filtering: wb_en=0 to R7 and a load to R0.
    drive(1'b1, 1'b0, 4'd7, 32'h77, 1'b1, 4'd0, 32'h99, 4'd7, 4'd0, 1'b0);
    idle(4'd7, 4'd0, 1'b0);

    // Hazard: src2 ignored without two_src, then matched, then cleared after R9 pops.
    drive(1'b1, 1'b1, 4'd9, 32'h9999, 1'b1, 4'd1, 32'h1111, 4'd0, 4'd0, 1'b0);
    idle(4'd0, 4'd9, 1'b0);
    idle(4'd0, 4'd9, 1'b1);
    idle(4'd9, 4'd0, 1'b0);

    // Reset mid-stream with three entries pending.
    drive(1'b1, 1'b1, 4'd2, 32'h2, 1'b1, 4'd1, 32'h1, 4'd0, 4'd0, 1'b0);
    drive(1'b1, 1'b1, 4'd4, 32'h4, 1'b1, 4'd3, 32'h3, 4'd3, 4'd0, 1'b0);
    check("fill_level", 32'(exp_q.size()), 32'd3);
    pulse_reset();
    idle(4'd3, 4'd0, 1'b0);

    // Backpressure: loads and ALU requests every cycle.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 4'($urandom_range(1, 15)), $urandom, 1'b1, 4'($urandom_range(1, 15)), $urandom,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Randomized traffic including filtered requests.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) idle(4'd0, 4'd0, 1'b0);
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
